// File: rtl/seg7_pkg.sv
// Shared constants and the BCD-to-segment encoder for the 7-segment scan driver.
// Segment codes are active-low, packed as {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  // Entry [n] is the code for digit n (0..9); entry [0] sits in the low bits.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Non-BCD codes (10..15) render as a dash so bad data is visible on the display.
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] code;
    if (d > 4'd9) code = SEG_DASH;
    else          code = SEG_TABLE[d];
    return code;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: counts 0..DIV-1 and flags the last count with tick.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int             CW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  // tick is decoded from the count register so it is high for exactly one cycle per period.
  assign tick = (count == LAST);

  // Prescaler counter, wraps to zero after the last count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    count <= '0;
    else if (tick) count <= '0;
    else           count <= count + CW'(1);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver with leading-zero blanking and an
// anti-ghost blank cycle at every digit change. All outputs are registered.
//
// Input handshake: load is a one-cycle strobe with no ready/back-pressure; on
// any rising edge where load=1 and reset is released, digits_in and dp_in are
// captured into the shadow registers. Holding load high recaptures every cycle.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int REFRESH_HZ = 1_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int DIV = CLK_HZ / REFRESH_HZ;

  logic        tick;
  logic [1:0]  idx;
  logic [15:0] shadow_digits;
  logic [3:0]  shadow_dp;
  logic [3:0]  cur_digit;
  logic        cur_dp;
  logic        upper_zero;
  logic        blank_cur;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Select the digit being scanned and decide whether it is a leading zero.
  always_comb begin
    cur_digit  = shadow_digits[{idx, 2'b00} +: 4];
    cur_dp     = shadow_dp[idx];
    upper_zero = 1'b0;
    case (idx)
      2'd3:    upper_zero = (shadow_digits[15:12] == 4'd0);
      2'd2:    upper_zero = (shadow_digits[15:8]  == 8'd0);
      2'd1:    upper_zero = (shadow_digits[15:4]  == 12'd0);
      default: upper_zero = 1'b0;
    endcase
    blank_cur = blank_lz && upper_zero;
  end

  // Shadow registers hold the displayed value between load strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_digits <= '0;
      shadow_dp     <= '0;
    end else if (load) begin
      shadow_digits <= digits_in;
      shadow_dp     <= dp_in;
    end
  end

  // Digit index steps 0,1,2,3,0 once per prescaler period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    idx <= 2'd0;
    else if (tick) idx <= idx + 2'd1;
  end

  // Output stage: blank on the tick edge, otherwise drive the selected digit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= 4'b1111;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else if (tick) begin
      an  <= 4'b1111;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= blank_cur ? 4'b1111 : ~(4'b0001 << idx);
      seg <= blank_cur ? SEG_OFF : encode(cur_digit);
      dp  <= ~cur_dp;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with DIV=4: directed scenarios followed by random
// loads, all checked against a cycle-count based reference model.
module tb_seg7_scan_driver;

  localparam int CLK_HZ     = 8;
  localparam int REFRESH_HZ = 2;
  localparam int DIV        = CLK_HZ / REFRESH_HZ;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0] exp_q[$];

  // Reference model: edges since reset release, latched digits and dp requests.
  int          m_cycle;
  int          m_dig[4];
  bit          m_dp[4];
  logic [6:0]  enc_tab[16];

  seg7_scan_driver #(.CLK_HZ(CLK_HZ), .REFRESH_HZ(REFRESH_HZ)) dut (
    .clk       (clk),
    .reset     (reset),
    .digits_in (digits_in),
    .dp_in     (dp_in),
    .load      (load),
    .blank_lz  (blank_lz),
    .seg       (seg),
    .dp        (dp),
    .an        (an)
  );

  // Clock and encoder table.
  always #5 clk = ~clk;

  initial begin
    enc_tab[0] = 7'h40; enc_tab[1] = 7'h79; enc_tab[2] = 7'h24; enc_tab[3] = 7'h30;
    enc_tab[4] = 7'h19; enc_tab[5] = 7'h12; enc_tab[6] = 7'h02; enc_tab[7] = 7'h78;
    enc_tab[8] = 7'h00; enc_tab[9] = 7'h10;
    for (int i = 10; i < 16; i++) enc_tab[i] = 7'h3F;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_cycle = 0;
    for (int i = 0; i < 4; i++) begin
      m_dig[i] = 0;
      m_dp[i]  = 1'b0;
    end
  endtask

  // Expected outputs produced by the coming edge, from the model state before it.
  function automatic logic [11:0] model_expect(input logic blz);
    int         pos;
    int         slot;
    bit         lead;
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    pos  = m_cycle % DIV;
    slot = (m_cycle / DIV) % 4;
    if (pos == DIV - 1) begin
      ea = 4'b1111; es = 7'h7F; ed = 1'b1;
    end else begin
      lead = (slot != 0);
      for (int j = slot; j < 4; j++) if (m_dig[j] != 0) lead = 1'b0;
      lead = lead && blz;
      ea = lead ? 4'b1111 : (4'b1111 ^ (4'b0001 << slot));
      es = lead ? 7'h7F : enc_tab[m_dig[slot]];
      ed = ~m_dp[slot];
    end
    return {ea, es, ed};
  endfunction

  // One clock edge with reset released: predict, clock, update model, compare.
  task automatic cycle();
    logic [11:0] e;
    exp_q.push_back(model_expect(blank_lz));
    @(posedge clk);
    if (load) begin
      for (int i = 0; i < 4; i++) begin
        m_dig[i] = int'(digits_in[4*i +: 4]);
        m_dp[i]  = dp_in[i];
      end
    end
    m_cycle++;
    #1;
    e = exp_q.pop_front();
    check("an",  {12'd0, an},  {12'd0, e[11:8]});
    check("seg", {9'd0, seg},  {9'd0, e[7:1]});
    check("dp",  {15'd0, dp},  {15'd0, e[0]});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    digits_in = d;
    dp_in     = p;
    load      = 1'b1;
    cycle();
    load      = 1'b0;
  endtask

  task automatic check_blank(input string tag);
    check({tag, "_an"},  {12'd0, an}, 16'h000F);
    check({tag, "_seg"}, {9'd0, seg}, 16'h007F);
    check({tag, "_dp"},  {15'd0, dp}, 16'h0001);
  endtask

  initial begin
    reset     = 1'b1;
    load      = 1'b0;
    blank_lz  = 1'b0;
    digits_in = 16'h0000;
    dp_in     = 4'h0;
    model_reset();

    // Reset asserted with no clock edge involved yet.
    #2 reset = 1'b0;
    #1 check_blank("reset_async_start");

    // A load during reset must be ignored.
    @(posedge clk); #1;
    digits_in = 16'hFFFF; dp_in = 4'hF; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    check_blank("reset_hold");

    // Release: first edge shows digit 0 with the reset-time (zero) shadow.
    reset = 1'b1;
    model_reset();
    cycle();
    check("first_an",  {12'd0, an}, 16'h000E);
    check("first_seg", {9'd0, seg}, 16'h0040);
    run(15);

    // Mixed digits with a decimal point on digit 2.
    do_load(16'h1234, 4'b0100);
    run(16);

    // Single significant digit with leading-zero blanking.
    blank_lz = 1'b1;
    do_load(16'h0007, 4'b0000);
    run(16);

    // Non-BCD digit renders as a dash; blanking only the upper digits.
    blank_lz = 1'b0;
    do_load(16'h00A0, 4'b0000);
    run(16);
    blank_lz = 1'b1;
    run(16);

    // Blanked digit with a decimal-point request.
    do_load(16'h0005, 4'b1000);
    run(16);
    blank_lz = 1'b0;

    // Load coincident with the tick edge.
    while ((m_cycle % DIV) != DIV - 1) cycle();
    do_load(16'h9876, 4'b0001);
    run(8);

    // Load in the middle of a digit slot.
    while ((m_cycle % DIV) != 1) cycle();
    do_load(16'h4321, 4'b0010);
    run(8);

    // Asynchronous reset during a lit slot, then restart at digit 0.
    while ((m_cycle % DIV) != 1) cycle();
    check("lit_before_reset", {12'd0, an}, 16'h000F ^ (16'h0001 << ((m_cycle / DIV) % 4)));
    #2 reset = 1'b0;
    #1 check_blank("reset_async_mid");
    @(posedge clk); #1;
    check_blank("reset_mid_hold");
    reset = 1'b1;
    model_reset();
    cycle();
    check("restart_an",  {12'd0, an}, 16'h000E);
    check("restart_seg", {9'd0, seg}, 16'h0040);
    run(7);

    // Random loads and blanking changes.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < 4; i++)
          digits_in[4*i +: 4] = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(0, 15));
        dp_in = 4'($urandom_range(0, 15));
        load  = 1'b1;
      end
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      cycle();
      load = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
